poly_pointwise_seq: RTL and testbench
=====================================

// Module: poly_pointwise_seq
// PURPOSE
//  Sequencer that runs one Kyber pointwise coefficient product c[i] = a[i]*b[i] mod q (q=3329) over N coefficients.
//  It sits directly upstream of the pipelined modular multiplier (registered inputs -> product reg -> reduce).
//  Per coefficient it reads a[i] and b[i] from two read-only coefficient RAMs and drives the pair into the multiplier.
//  It tracks each in-flight index through the multiplier latency and writes the reduced result into the output RAM.
//  The multiplier is external; this block has no arithmetic other than counting and a range check.
// PARAMETERS
//  N        256  coefficients per polynomial
//  AW       8    address width, N <= 2**AW
//  DW       12   coefficient width
//  RD_LAT   1    cycles from a_ren/addr to valid a_rdata/b_rdata (>=1)
//  MUL_LAT  4    cycles from mul_in1/mul_in2 valid to mul_res valid (>=1)
// PORTS
//  clk       in   1   rising-edge clock, single domain
//  rst_n     in   1   asynchronous, active-low reset
//  start     in   1   begin a pass; sampled only in IDLE
//  busy      out  1   pass in progress
//  done      out  1   one-cycle pulse, pass complete
//  err       out  1   sticky: an operand >= 3329 was consumed this pass
//  rd_addr   out  AW  shared read address for A and B RAMs
//  rd_en     out  1   read enable for A and B RAMs
//  a_rdata   in   DW  A coefficient read data
//  b_rdata   in   DW  B coefficient read data
//  mul_in1   out  DW  operand 1 to multiplier (= a_rdata, passthrough)
//  mul_in2   out  DW  operand 2 to multiplier (= b_rdata, passthrough)
//  mul_res   in   DW  reduced product from multiplier
//  c_wen     out  1   output RAM write enable
//  c_waddr   out  AW  output RAM write address
//  c_wdata   out  DW  output RAM write data (= mul_res)
// BEHAVIOUR
//  Reset:
//   - rst_n low clears all of these asynchronously: busy, done, err, rd_en, c_wen, rd_addr, c_waddr, the issue counter and the delay line.
//   - The FSM returns to IDLE.
//   - Reset mid-pass aborts the pass; no c_wen is produced for in-flight indices.
//  FSM: IDLE -> ISSUE -> DRAIN -> FIN -> IDLE.
//   - IDLE: start=1 at edge t0 -> ISSUE; err is cleared at the same edge.
//   - ISSUE: rd_en=1 with rd_addr=k in cycle t0+1+k, for k=0..N-1, one per cycle with no bubbles. After k=N-1 -> DRAIN.
//   - DRAIN: rd_en=0; waits until the write of index N-1 has happened, then -> FIN.
//   - FIN: done=1 and busy=0 for exactly one cycle, then -> IDLE.
//  busy=1 in ISSUE and DRAIN: cycles t0+1 .. t0+N+L, where L = RD_LAT+MUL_LAT.
//  Tracking:
//   - A shift line of depth L carries {valid, index}. Stage 0 is loaded from {rd_en, rd_addr}.
//   - Output of the line: c_wen = valid, c_waddr = index, c_wdata = mul_res.
//   - Index k is written in cycle t0+1+k+L. Writes occur in strictly ascending address order, exactly N writes per pass.
//  Range check:
//   - In the cycle RD_LAT after each read, if a_rdata >= 3329 or b_rdata >= 3329, err is set.
//   - err holds until the next accepted start or reset. The pass still completes.
//  Other rules:
//   - mul_in1/mul_in2 are not gated: they follow the RAM data in every cycle. The multiplier's own input registers capture them.
//   - start while busy or in FIN is ignored; no queuing.
//   - start held high continuously gives back-to-back passes separated by the FIN cycle plus one IDLE cycle.
//   - Counters are sized AW+1 internally. The issue counter stops at N-1 with no wrap. No write to an address >= N ever occurs.
// TESTING
//  1. Basic pass, defaults. a[i]=i, b[i]=2: start at t0 -> c[i]=2i for i<256; 256 writes, the last at t0+261; done pulse at t0+262; err=0.
//  2. Modular wrap. a[i]=b[i]=3328 for all i -> every c[i]=1. a[0]=1664, b[0]=2 -> c[0]=3328.
//  3. Range error. a[17]=3329 -> err=1 from the cycle after index 17 is consumed to the end of the pass; done still pulses. Next start clears err.
//  4. Reset mid-pass. Pull rst_n low at t0+100, release at t0+103 -> busy=0, no c_wen after reset. A new start runs a full, correct 256-write pass.
//  5. Start ignored and back-to-back. Pulse start at t0+50 -> no effect. Hold start high -> second pass rd_en rises exactly 2 cycles after the first done.
//  6. Latency sweep. RD_LAT=2, MUL_LAT=3, N=16 -> index k written at t0+6+k; done at t0+22; write addresses are 0..15 with no gaps.

Source files
------------

// File: rtl/poly_pointwise_seq.sv
// Pointwise-product sequencer: streams a[i], b[i] into an external modular
// multiplier and writes each reduced result back to c[i] in index order.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                begin a pass (sampled in IDLE only)
//   busy, done, err      pass active, one-cycle completion pulse, sticky range error
//   rd_addr, rd_en       shared read port for the A and B coefficient RAMs
//   a_rdata, b_rdata     RAM read data, RD_LAT cycles after rd_en
//   mul_in1, mul_in2     multiplier operands (straight from RAM data)
//   mul_res              reduced product, MUL_LAT cycles after operands
//   c_wen, c_waddr,      output RAM write port
//   c_wdata
module poly_pointwise_seq #(
    parameter int N       = 256,
    parameter int AW      = 8,
    parameter int DW      = 12,
    parameter int RD_LAT  = 1,
    parameter int MUL_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] rd_addr,
    output logic          rd_en,
    input  logic [DW-1:0] a_rdata,
    input  logic [DW-1:0] b_rdata,
    output logic [DW-1:0] mul_in1,
    output logic [DW-1:0] mul_in2,
    input  logic [DW-1:0] mul_res,
    output logic          c_wen,
    output logic [AW-1:0] c_waddr,
    output logic [DW-1:0] c_wdata
);

    localparam int L = RD_LAT + MUL_LAT;
    localparam logic [AW:0]   LAST = (AW+1)'(N - 1);
    localparam logic [DW-1:0] Q    = DW'(3329);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          rd_en_q, rd_en_d;
    logic          err_q, err_d;

    // Delay line: {valid, index} per in-flight coefficient, depth L.
    logic [L-1:0]  vld_q;
    logic [AW-1:0] idx_q [L];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_en_d = rd_en_q;
        err_d   = err_q;

        // Stage RD_LAT-1 lines up with the RAM data of that read.
        if (vld_q[RD_LAT-1] && (a_rdata >= Q || b_rdata >= Q)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                    rd_en_d = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (cnt_q == LAST) begin
                    state_d = S_DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (vld_q[L-1] && idx_q[L-1] == LAST[AW-1:0]) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_en_q <= rd_en_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < L; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q    <= {vld_q[L-2:0], rd_en_q};
            idx_q[0] <= cnt_q[AW-1:0];
            for (int i = 1; i < L; i++) begin
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done    = (state_q == S_FIN);
    assign err     = err_q;
    assign rd_addr = cnt_q[AW-1:0];
    assign rd_en   = rd_en_q;
    assign mul_in1 = a_rdata;
    assign mul_in2 = b_rdata;
    assign c_wen   = vld_q[L-1];
    assign c_waddr = idx_q[L-1];
    assign c_wdata = mul_res;

endmodule

// File: tb/tb_poly_pointwise_seq.sv
// Testbench for poly_pointwise_seq: RAM and multiplier models around a
// default instance and a short-latency-sweep instance, scoreboard checked.
module tb_poly_pointwise_seq;

    localparam int N   = 256;
    localparam int N2  = 16;
    localparam int Q   = 3329;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    // ---------------- instance 1: defaults ----------------
    logic        start = 1'b0;
    logic        busy, done, err, rd_en, c_wen;
    logic [7:0]  rd_addr, c_waddr;
    logic [11:0] a_rdata = '0, b_rdata = '0;
    logic [11:0] mul_in1, mul_in2, mul_res, c_wdata;
    logic [11:0] a_mem [N];
    logic [11:0] b_mem [N];
    logic [11:0] mp [4];

    poly_pointwise_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .err(err),
        .rd_addr(rd_addr), .rd_en(rd_en),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_res(mul_res),
        .c_wen(c_wen), .c_waddr(c_waddr), .c_wdata(c_wdata)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata <= a_mem[rd_addr];
            b_rdata <= b_mem[rd_addr];
        end
        mp[0] <= 12'((int'(mul_in1) * int'(mul_in2)) % Q);
        for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
    end
    assign mul_res = mp[3];

    // ---------------- instance 2: N=16, RD_LAT=2, MUL_LAT=3 ----------------
    logic        start2 = 1'b0;
    logic        busy2, done2, err2, rd_en2, c_wen2;
    logic [3:0]  rd_addr2, c_waddr2;
    logic [11:0] a2_p = '0, b2_p = '0, a2_rdata = '0, b2_rdata = '0;
    logic [11:0] mul2_in1, mul2_in2, mul2_res, c_wdata2;
    logic [11:0] a2_mem [N2];
    logic [11:0] b2_mem [N2];
    logic [11:0] mp2 [3];

    poly_pointwise_seq #(.N(N2), .AW(4), .DW(12), .RD_LAT(2), .MUL_LAT(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .busy(busy2), .done(done2), .err(err2),
        .rd_addr(rd_addr2), .rd_en(rd_en2),
        .a_rdata(a2_rdata), .b_rdata(b2_rdata),
        .mul_in1(mul2_in1), .mul_in2(mul2_in2), .mul_res(mul2_res),
        .c_wen(c_wen2), .c_waddr(c_waddr2), .c_wdata(c_wdata2)
    );

    always @(posedge clk) begin
        if (rd_en2) begin
            a2_p <= a2_mem[rd_addr2];
            b2_p <= b2_mem[rd_addr2];
        end
        a2_rdata <= a2_p;
        b2_rdata <= b2_p;
        mp2[0] <= 12'((int'(mul2_in1) * int'(mul2_in2)) % Q);
        for (int i = 1; i < 3; i++) mp2[i] <= mp2[i-1];
    end
    assign mul2_res = mp2[2];

    // ---------------- monitors ----------------
    int wr1 = 0, last_wr1 = 0, dn1 = 0, done_cyc1 = 0, rise1 = 0, err_rise1 = 0;
    bit rd_prev1 = 0, err_prev1 = 0;
    int c_mem [N];
    int wr2 = 0, last_wr2 = 0, wr0_cyc2 = 0, dn2 = 0, done_cyc2 = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q1.delete();
            q2.delete();
            rd_prev1 = 0;
            err_prev1 = 0;
        end else begin
            if (c_wen) begin
                wr1++;
                last_wr1 = cyc;
                c_mem[c_waddr] = int'(c_wdata);
                if (q1.size() == 0) begin
                    chk("c1 unexpected write addr", int'(c_waddr), -1);
                end else begin
                    e = q1.pop_front();
                    chk("c1 waddr", int'(c_waddr), e.addr);
                    chk("c1 wdata", int'(c_wdata), e.data);
                end
            end
            if (done) begin
                dn1++;
                done_cyc1 = cyc;
            end
            if (rd_en && !rd_prev1) rise1 = cyc;
            if (err && !err_prev1) err_rise1 = cyc;
            rd_prev1 = rd_en;
            err_prev1 = err;
            if (c_wen2) begin
                wr2++;
                last_wr2 = cyc;
                if (c_waddr2 == 4'd0) wr0_cyc2 = cyc;
                if (q2.size() == 0) begin
                    chk("c2 unexpected write addr", int'(c_waddr2), -1);
                end else begin
                    e = q2.pop_front();
                    chk("c2 waddr", int'(c_waddr2), e.addr);
                    chk("c2 wdata", int'(c_wdata2), e.data);
                end
            end
            if (done2) begin
                dn2++;
                done_cyc2 = cyc;
            end
        end
    end

    // ---------------- helpers ----------------
    typedef struct {
        int a_kind;
        int b_val;
        bit fix0;
        int bad;
        bit exp_err;
        int exp_c0;
        int exp_cl;
    } vec_t;

    task automatic load1(input vec_t v);
        for (int i = 0; i < N; i++) begin
            a_mem[i] = (v.a_kind == 0) ? 12'(i) : 12'd3328;
            b_mem[i] = 12'(v.b_val);
        end
        if (v.fix0) begin
            a_mem[0] = 12'd1664;
            b_mem[0] = 12'd2;
        end
        if (v.bad >= 0) a_mem[v.bad] = 12'd3329;
    endtask

    task automatic push1();
        for (int i = 0; i < N; i++)
            q1.push_back('{i, (int'(a_mem[i]) * int'(b_mem[i])) % Q});
    endtask

    task automatic start1(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int which, input int maxc, output bit ok);
        int d0;
        d0 = (which == 1) ? dn1 : dn2;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            if (((which == 1) ? dn1 : dn2) != d0) begin
                ok = 1;
                break;
            end
        end
        #1;
    endtask

    task automatic run_row(input vec_t v);
        int t0, w0;
        bit ok;
        load1(v);
        push1();
        w0 = wr1;
        start1(t0);
        wait_done(1, 400, ok);
        chk("pass done seen", int'(ok), 1);
        chk("write count", wr1 - w0, N);
        chk("first rd_en offset", rise1 - t0, 1);
        chk("last write offset", last_wr1 - t0, N + 5);
        chk("done offset", done_cyc1 - t0, N + 6);
        chk("err at end", int'(err), int'(v.exp_err));
        chk("c[0]", c_mem[0], v.exp_c0);
        chk("c[N-1]", c_mem[N-1], v.exp_cl);
        if (v.bad >= 0) chk("err rise offset", err_rise1 - t0, v.bad + 3);
    endtask

    // ---------------- test sequence ----------------
    vec_t vt [4];

    initial begin
        int t0, w0, d0, dfirst, r0;
        bit ok;

        vt[0] = '{0, 2,    0, -1, 0, 0,    510};
        vt[1] = '{1, 3328, 1, -1, 0, 3328, 1};
        vt[2] = '{0, 2,    0, 17, 1, 0,    510};
        vt[3] = '{0, 5,    0, -1, 0, 0,    1275};

        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        chk("reset rd_en", int'(rd_en), 0);
        chk("reset c_wen", int'(c_wen), 0);
        chk("reset rd_addr", int'(rd_addr), 0);
        chk("reset c_waddr", int'(c_waddr), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 4; r++) run_row(vt[r]);

        // Reset in the middle of a pass.
        load1(vt[0]);
        push1();
        start1(t0);
        while (cyc < t0 + 100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid-reset busy", int'(busy), 0);
        chk("mid-reset c_wen", int'(c_wen), 0);
        chk("mid-reset rd_en", int'(rd_en), 0);
        while (cyc < t0 + 103) @(negedge clk);
        rst_n = 1'b1;
        w0 = wr1;
        repeat (20) @(negedge clk);
        chk("writes after reset", wr1 - w0, 0);
        chk("busy after reset", int'(busy), 0);
        run_row(vt[0]);

        // Start pulse during a pass is ignored.
        load1(vt[3]);
        push1();
        w0 = wr1;
        d0 = dn1;
        start1(t0);
        while (cyc < t0 + 50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, 400, ok);
        chk("ignored-start done seen", int'(ok), 1);
        repeat (20) @(negedge clk);
        chk("ignored-start writes", wr1 - w0, N);
        chk("ignored-start done count", dn1 - d0, 1);
        chk("ignored-start no re-issue", rise1 - t0, 1);

        // Start held high: back-to-back passes.
        push1();
        push1();
        w0 = wr1;
        @(negedge clk);
        start = 1'b1;
        wait_done(1, 400, ok);
        chk("b2b first done seen", int'(ok), 1);
        dfirst = done_cyc1;
        r0 = rise1;
        for (int i = 0; i < 10 && rise1 == r0; i++) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b rd_en after done", rise1 - dfirst, 2);
        wait_done(1, 400, ok);
        chk("b2b second done seen", int'(ok), 1);
        repeat (5) @(negedge clk);
        chk("b2b writes", wr1 - w0, 2 * N);
        chk("b2b busy idle", int'(busy), 0);
        chk("q1 drained", q1.size(), 0);

        // Latency sweep instance.
        for (int i = 0; i < N2; i++) begin
            a2_mem[i] = 12'(i + 100);
            b2_mem[i] = 12'd3;
            q2.push_back('{i, ((i + 100) * 3) % Q});
        end
        @(negedge clk);
        start2 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start2 = 1'b0;
        wait_done(2, 100, ok);
        chk("sweep done seen", int'(ok), 1);
        chk("sweep first write offset", wr0_cyc2 - t0, 6);
        chk("sweep last write offset", last_wr2 - t0, 21);
        chk("sweep done offset", done_cyc2 - t0, 22);
        chk("sweep write count", wr2, N2);
        chk("sweep err", int'(err2), 0);
        chk("q2 drained", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
